sd_spi_cmd_engine: RTL and testbench

//   Host-side SPI-mode command engine. Drives the SD card interface (sd_clk/cs_n/mosi) and

---
 rtl/sd_pkg.sv | 38 +++
 rtl/sd_crc7.sv | 40 ++++
 rtl/sd_spi_cmd_engine.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_sd_spi_cmd_engine.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// -----------------------------------------------------------------------------
// sd_pkg
//   Shared definitions for the SD SPI-mode command engine:
//   - sd_state_t     : engine FSM state encoding
//   - CMDx / ACMD41  : commonly used SD command indices
//   - RESP_R1_BITS / RESP_R7_BITS : response lengths in bits
//   - PREPOST_CLKS   : sd_clk cycles with cs_n high before/after a command
//   - sd_frame_head  : first 40 bits of a command frame (start, tx, idx, arg)
// -----------------------------------------------------------------------------
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_RECV = 3'd4,
    ST_POST = 3'd5
  } sd_state_t;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD17  = 6'd17;
  localparam logic [5:0] CMD24  = 6'd24;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] ACMD41 = 6'd41;

  localparam int RESP_R1_BITS = 8;
  localparam int RESP_R7_BITS = 40;
  localparam int PREPOST_CLKS = 8;

  // Start bit 0, transmission bit 1, then index and argument.
  function automatic logic [39:0] sd_frame_head(input logic [5:0]  idx,
                                                input logic [31:0] arg);
    return {2'b01, idx, arg};
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// -----------------------------------------------------------------------------
// sd_crc7
//   Serial CRC7 (x^7 + x^3 + 1, initial value 0), one bit per enabled clock,
//   MSB of the message first.
// Ports
//   clk   in  1  system clock
//   rst_n in  1  asynchronous active-low reset
//   clr   in  1  synchronous clear to 0 (has priority over en)
//   en    in  1  shift din into the CRC this clock
//   din   in  1  message bit
//   crc   out 7  current CRC value
// -----------------------------------------------------------------------------
module sd_crc7 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_reg;
  logic       fb;

  assign fb = din ^ crc_reg[6];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_reg <= '0;
    end else if (clr) begin
      crc_reg <= '0;
    end else if (en) begin
      // Feedback taps at x^3 and x^0.
      crc_reg <= {crc_reg[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    end
  end

  assign crc = crc_reg;

endmodule

// File: rtl/sd_spi_cmd_engine.sv
// -----------------------------------------------------------------------------
// sd_spi_cmd_engine
//   Host-side SPI-mode (mode 0) SD command engine. Sends one 48-bit command
//   frame MSB first, polls for the response start bit, collects an R1 (8 bit)
//   or R7/R3 (40 bit) response and hands it back through a valid/ready pair.
//   Sequence: 8 idle clocks with cs_n high, frame, response poll/receive,
//   8 trailing clocks with cs_n high.
// Parameters
//   CLK_DIV       clk cycles per sd_clk half period (>= 1)
//   RESP_TIMEOUT  sd_clk rising edges polled for a start bit (1..255)
// Configuration macro
//   SD_CMD_CRC_GEN_EN : CRC7 is generated on the fly over frame bits 47..8
//                       and cmd_crc is ignored; otherwise cmd_crc is sent as is.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready command handshake (accepted only when idle)
//   cmd_idx/arg/crc     command fields, resp_long selects 40-bit response
//   resp_valid          1-clk pulse when a response or timeout is complete
//   resp_data           response, right aligned; resp_timeout: no start bit
//   busy                high from accept until resp_valid
//   sd_clk/cs_n/mosi    SPI outputs to the card, sd_miso card data input
// -----------------------------------------------------------------------------
module sd_spi_cmd_engine
  import sd_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_idx,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  input  logic        resp_long,
  output logic        resp_valid,
  output logic [39:0] resp_data,
  output logic        resp_timeout,
  output logic        busy,
  output logic        sd_clk,
  output logic        sd_cs_n,
  output logic        sd_mosi,
  input  logic        sd_miso
);

  localparam int               DIV_W     = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [7:0]       TMO_LAST  = 8'(RESP_TIMEOUT - 1);
  localparam logic [5:0]       PP_CNT    = 6'(PREPOST_CLKS);
  localparam logic [5:0]       R1_REST   = 6'(RESP_R1_BITS - 1);
  localparam logic [5:0]       R7_REST   = 6'(RESP_R7_BITS - 1);
  localparam logic [5:0]       FRAME_LEN = 6'd48;
  localparam logic [5:0]       HEAD_LEN  = 6'd40;

  sd_state_t        state_reg, state_next;
  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic             sd_clk_reg, sd_clk_next;
  logic             cs_n_reg, cs_n_next;
  logic             mosi_reg, mosi_next;
  logic [5:0]       bit_cnt_reg, bit_cnt_next;
  logic [7:0]       tmo_cnt_reg, tmo_cnt_next;
  logic             tmo_flag_reg, tmo_flag_next;
  logic             long_reg, long_next;
  logic [39:0]      head_reg, head_next;
  logic [39:0]      rx_shift_reg, rx_shift_next;
  logic             resp_valid_reg, resp_valid_next;
  logic [39:0]      resp_data_reg, resp_data_next;
  logic             resp_timeout_reg, resp_timeout_next;

  logic             accept;
  logic             tick;
  logic             rise;
  logic             fall;
  logic [5:0]       drive_pos;
  logic [6:0]       crc_field;
  logic [47:0]      tx_word;

  assign accept = (state_reg == ST_IDLE) && cmd_valid;

  // sd_clk only runs outside IDLE; tick marks the clk on which it toggles.
  assign tick = (state_reg != ST_IDLE) && (div_cnt_reg == DIV_LAST);
  assign rise = tick && !sd_clk_reg;
  assign fall = tick &&  sd_clk_reg;

  assign tx_word = {head_reg, crc_field, 1'b1};

  // Bit about to be driven on a falling edge: bit 47 at the end of PRE,
  // otherwise the bit after the ones already clocked out in SEND.
  assign drive_pos = (state_reg == ST_PRE) ? 6'd47 : (6'd47 - bit_cnt_reg);

`ifdef SD_CMD_CRC_GEN_EN
  logic crc_en;

  // Feed every header bit (47..8) into the CRC as it goes onto mosi, so the
  // CRC is final before bit 7 is needed.
  assign crc_en = fall &&
                  (((state_reg == ST_PRE)  && (bit_cnt_reg == PP_CNT)) ||
                   ((state_reg == ST_SEND) && (bit_cnt_reg <  HEAD_LEN)));

  sd_crc7 u_crc7 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (crc_en),
    .din   (tx_word[drive_pos]),
    .crc   (crc_field)
  );
`else
  logic [6:0] crc_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_reg <= '0;
    end else if (accept) begin
      crc_reg <= cmd_crc;
    end
  end

  assign crc_field = crc_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      div_cnt_reg      <= '0;
      sd_clk_reg       <= 1'b0;
      cs_n_reg         <= 1'b1;
      mosi_reg         <= 1'b1;
      bit_cnt_reg      <= '0;
      tmo_cnt_reg      <= '0;
      tmo_flag_reg     <= 1'b0;
      long_reg         <= 1'b0;
      head_reg         <= '0;
      rx_shift_reg     <= '0;
      resp_valid_reg   <= 1'b0;
      resp_data_reg    <= '0;
      resp_timeout_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      div_cnt_reg      <= div_cnt_next;
      sd_clk_reg       <= sd_clk_next;
      cs_n_reg         <= cs_n_next;
      mosi_reg         <= mosi_next;
      bit_cnt_reg      <= bit_cnt_next;
      tmo_cnt_reg      <= tmo_cnt_next;
      tmo_flag_reg     <= tmo_flag_next;
      long_reg         <= long_next;
      head_reg         <= head_next;
      rx_shift_reg     <= rx_shift_next;
      resp_valid_reg   <= resp_valid_next;
      resp_data_reg    <= resp_data_next;
      resp_timeout_reg <= resp_timeout_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    div_cnt_next      = div_cnt_reg;
    sd_clk_next       = sd_clk_reg;
    cs_n_next         = cs_n_reg;
    mosi_next         = mosi_reg;
    bit_cnt_next      = bit_cnt_reg;
    tmo_cnt_next      = tmo_cnt_reg;
    tmo_flag_next     = tmo_flag_reg;
    long_next         = long_reg;
    head_next         = head_reg;
    rx_shift_next     = rx_shift_reg;
    resp_valid_next   = 1'b0;
    resp_data_next    = resp_data_reg;
    resp_timeout_next = resp_timeout_reg;

    if (state_reg == ST_IDLE) begin
      div_cnt_next = '0;
      sd_clk_next  = 1'b0;
      cs_n_next    = 1'b1;
      mosi_next    = 1'b1;
      if (accept) begin
        state_next    = ST_PRE;
        bit_cnt_next  = '0;
        tmo_cnt_next  = '0;
        tmo_flag_next = 1'b0;
        long_next     = resp_long;
        head_next     = sd_frame_head(cmd_idx, cmd_arg);
        rx_shift_next = '0;
      end
    end else begin
      if (tick) begin
        div_cnt_next = '0;
        sd_clk_next  = ~sd_clk_reg;
      end else begin
        div_cnt_next = div_cnt_reg + DIV_ONE;
      end

      case (state_reg)
        ST_PRE: begin
          if (rise) begin
            bit_cnt_next = bit_cnt_reg + 6'd1;
          end else if (fall && (bit_cnt_reg == PP_CNT)) begin
            state_next   = ST_SEND;
            cs_n_next    = 1'b0;
            mosi_next    = tx_word[drive_pos];
            bit_cnt_next = '0;
          end
        end

        // bit_cnt counts bits already sampled by the card.
        ST_SEND: begin
          if (rise) begin
            bit_cnt_next = bit_cnt_reg + 6'd1;
          end else if (fall) begin
            if (bit_cnt_reg == FRAME_LEN) begin
              state_next = ST_WAIT;
              mosi_next  = 1'b1;
            end else begin
              mosi_next  = tx_word[drive_pos];
            end
          end
        end

        ST_WAIT: begin
          if (rise) begin
            if (!sd_miso) begin
              // Start bit is the response MSB and is always 0.
              rx_shift_next = {rx_shift_reg[38:0], 1'b0};
              bit_cnt_next  = long_reg ? R7_REST : R1_REST;
              state_next    = ST_RECV;
            end else if (tmo_cnt_reg == TMO_LAST) begin
              tmo_flag_next = 1'b1;
              bit_cnt_next  = '0;
              cs_n_next     = 1'b1;
              state_next    = ST_POST;
            end else begin
              tmo_cnt_next  = tmo_cnt_reg + 8'd1;
            end
          end
        end

        // bit_cnt counts bits still to be received.
        ST_RECV: begin
          if (rise) begin
            rx_shift_next = {rx_shift_reg[38:0], sd_miso};
            if (bit_cnt_reg == 6'd1) begin
              bit_cnt_next = '0;
              cs_n_next    = 1'b1;
              state_next   = ST_POST;
            end else begin
              bit_cnt_next = bit_cnt_reg - 6'd1;
            end
          end
        end

        // Eight full clocks; the falling edge after the eighth rise returns
        // sd_clk to its idle level and completes the command.
        ST_POST: begin
          if (rise) begin
            bit_cnt_next = bit_cnt_reg + 6'd1;
          end else if (fall && (bit_cnt_reg == PP_CNT)) begin
            state_next        = ST_IDLE;
            resp_valid_next   = 1'b1;
            resp_data_next    = rx_shift_reg;
            resp_timeout_next = tmo_flag_reg;
          end
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready    = (state_reg == ST_IDLE);
  assign busy         = (state_reg != ST_IDLE);
  assign resp_valid   = resp_valid_reg;
  assign resp_data    = resp_data_reg;
  assign resp_timeout = resp_timeout_reg;
  assign sd_clk       = sd_clk_reg;
  assign sd_cs_n      = cs_n_reg;
  assign sd_mosi      = mosi_reg;

endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
module tb_sd_spi_cmd_engine;
  import sd_pkg::*;

  localparam int CLK_DIV      = 2;
  localparam int RESP_TIMEOUT = 64;
  localparam int FRAME_BITS   = 48;
  localparam int PP           = 8;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [5:0]  cmd_idx   = '0;
  logic [31:0] cmd_arg   = '0;
  logic [6:0]  cmd_crc   = '0;
  logic        resp_long = 1'b0;
  logic        sd_miso   = 1'b1;
  logic        cmd_ready;
  logic        resp_valid;
  logic [39:0] resp_data;
  logic        resp_timeout;
  logic        busy;
  logic        sd_clk;
  logic        sd_cs_n;
  logic        sd_mosi;

  sd_spi_cmd_engine #(
    .CLK_DIV      (CLK_DIV),
    .RESP_TIMEOUT (RESP_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_idx      (cmd_idx),
    .cmd_arg      (cmd_arg),
    .cmd_crc      (cmd_crc),
    .resp_long    (resp_long),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_timeout (resp_timeout),
    .busy         (busy),
    .sd_clk       (sd_clk),
    .sd_cs_n      (sd_cs_n),
    .sd_mosi      (sd_mosi),
    .sd_miso      (sd_miso)
  );

  always #5 clk = ~clk;

  int          n_checks   = 0;
  int          n_errors   = 0;
  int          n_txn      = 0;
  int          rv_count   = 0;
  logic [39:0] card_resp  = '0;
  int          card_nbits = 8;
  int          card_delay = 1000;
  int          base_idx   = 0;
  bit          rec_cs[$];
  bit          rec_mosi[$];
  logic        prev_sclk  = 1'b0;
  logic        prev_cs    = 1'b1;
  logic        prev_mosi  = 1'b1;
  logic [47:0] last_frame = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] crc7_model(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // Card model: after the 8 + 48 rising edges of preamble and frame, the card
  // returns card_delay ones, then card_nbits response bits MSB first, then ones.
  function automatic logic card_bit(input int e);
    int k;
    int j;
    k = e - (PP + FRAME_BITS);
    if (k < card_delay) return 1'b1;
    j = k - card_delay;
    if (j < card_nbits) return card_resp[card_nbits-1-j];
    return 1'b1;
  endfunction

  // Records cs_n/mosi as seen by the card at each sd_clk rising edge and
  // updates miso after each falling edge (SPI mode 0).
  always @(negedge clk) begin
    if (!prev_sclk && sd_clk) begin
      rec_cs.push_back(prev_cs);
      rec_mosi.push_back(prev_mosi);
    end
    if (prev_sclk && !sd_clk) sd_miso = card_bit(rec_cs.size() - base_idx);
    if (resp_valid === 1'b1) rv_count++;
    prev_sclk = sd_clk;
    prev_cs   = sd_cs_n;
    prev_mosi = sd_mosi;
  end

  task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                         input logic lng, input logic [39:0] resp, input int delay, input bit inject);
    int          nb;
    int          w;
    int          n;
    int          bad;
    int          waited;
    logic        exp_tmo;
    logic [39:0] exp_data;
    logic [6:0]  crc_exp;
    logic [47:0] exp_frame;
    logic [47:0] frame_got;
    bit          cs_e;
    bit          m_e;

    n_txn++;
    nb         = lng ? 40 : 8;
    card_resp  = resp;
    card_nbits = nb;
    card_delay = delay;
    base_idx   = rec_cs.size();
    exp_tmo    = (delay >= RESP_TIMEOUT);
    exp_data   = exp_tmo ? 40'd0 : resp;
`ifdef SD_CMD_CRC_GEN_EN
    crc_exp    = crc7_model({2'b01, idx, arg});
`else
    crc_exp    = crc;
`endif
    exp_frame  = {2'b01, idx, arg, crc_exp, 1'b1};

    cmd_idx   = idx;
    cmd_arg   = arg;
    cmd_crc   = crc;
    resp_long = lng;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    check_val("accept_ready", 64'(cmd_ready), 64'd0);
    check_val("accept_busy", 64'(busy), 64'd1);
    check_val("rv_one_clk", 64'(resp_valid), 64'd0);
    cmd_valid = 1'b0;
    cmd_idx   = 6'($urandom);
    cmd_arg   = $urandom;
    cmd_crc   = 7'($urandom);
    resp_long = 1'($urandom);

    if (inject) begin
      waited = 0;
      while ((rec_cs.size() - base_idx) < 20 && waited < 2000) begin
        @(negedge clk);
        waited++;
      end
      cmd_idx   = CMD55;
      cmd_valid = 1'b1;
      repeat (3) @(negedge clk);
      cmd_valid = 1'b0;
    end

    waited = 0;
    @(negedge clk);
    while (resp_valid !== 1'b1 && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    check_val("resp_valid", 64'(resp_valid), 64'd1);
    check_val("resp_data", 64'(resp_data), 64'(exp_data));
    check_val("resp_timeout", 64'(resp_timeout), 64'(exp_tmo));
    check_val("done_ready", 64'(cmd_ready), 64'd1);
    check_val("done_busy", 64'(busy), 64'd0);
    check_val("done_idle_lines", 64'({sd_clk, sd_cs_n, sd_mosi}), 64'(3'b011));

    w = exp_tmo ? RESP_TIMEOUT : delay + nb;
    n = rec_cs.size() - base_idx;
    check_val("edge_count", 64'(n), 64'(PP + FRAME_BITS + w + PP));
    bad       = 0;
    frame_got = '0;
    for (int i = 0; i < n; i++) begin
      cs_e = (i < PP) || (i >= PP + FRAME_BITS + w);
      m_e  = 1'b1;
      if (i >= PP && i < PP + FRAME_BITS) begin
        frame_got = {frame_got[46:0], rec_mosi[base_idx+i]};
        m_e = rec_mosi[base_idx+i];
      end
      if (rec_cs[base_idx+i] != cs_e || rec_mosi[base_idx+i] != m_e) bad++;
    end
    check_val("frame", 64'(frame_got), 64'(exp_frame));
    check_val("line_levels", 64'(bad), 64'd0);
    last_frame = frame_got;
    $display("txn %0d: idx=%0d arg=%h long=%0b delay=%0d inject=%0b frame=%h data=%h tmo=%0b",
             n_txn, idx, arg, lng, delay, inject, frame_got, resp_data, resp_timeout);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;

    repeat (3) @(negedge clk);
    check_val("rst_ready", 64'(cmd_ready), 64'd1);
    check_val("rst_outputs", 64'({resp_valid, resp_timeout, busy, sd_clk, sd_cs_n, sd_mosi}),
              64'(6'b000011));
    check_val("rst_data", 64'(resp_data), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // CMD0 with R1 idle response.
    run_txn(CMD0, 32'd0, 7'h4A, 1'b0, 40'h01, 1, 1'b0);
    check_val("cmd0_bytes", 64'(last_frame), 64'h4000_0000_0095);
    // CMD8 with R7 echo.
    run_txn(CMD8, 32'h1AA, 7'h43, 1'b1, 40'h01_0000_01AA, 2, 1'b0);
    check_val("cmd8_bytes", 64'(last_frame), 64'h4800_0001_AA87);
    // miso stuck high -> timeout.
    run_txn(CMD17, 32'h0000_0200, 7'h2A, 1'b0, 40'h00, 1000, 1'b0);
    // Start bit on the last polled edge, then one edge too late.
    run_txn(CMD24, 32'h0000_0400, 7'h11, 1'b0, 40'h05, RESP_TIMEOUT - 1, 1'b0);
    run_txn(ACMD41, 32'h4000_0000, 7'h3B, 1'b0, 40'h00, RESP_TIMEOUT, 1'b0);
    // CMD55 with a command pulsed during SEND (must be ignored).
    run_txn(CMD55, 32'd0, 7'h32, 1'b0, 40'h01, 3, 1'b1);
    check_val("cmd55_crc_byte", 64'(last_frame[7:0]), 64'h65);

    // Reset in the middle of SEND.
    cmd_idx   = CMD0;
    cmd_arg   = 32'd0;
    cmd_crc   = 7'h4A;
    resp_long = 1'b0;
    base_idx  = rec_cs.size();
    card_delay = 1000;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    waited = 0;
    while ((rec_cs.size() - base_idx) < 20 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check_val("pre_rst_cs", 64'(sd_cs_n), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_lines", 64'({sd_clk, sd_cs_n, sd_mosi}), 64'(3'b011));
    check_val("mid_rst_ready", 64'({cmd_ready, busy, resp_valid}), 64'(3'b100));
    check_val("mid_rst_data", 64'({resp_timeout, resp_data}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_txn(CMD0, 32'd0, 7'h4A, 1'b0, 40'h01, 0, 1'b0);
    check_val("post_rst_cmd0", 64'(last_frame), 64'h4000_0000_0095);

    // Randomized commands, issued back to back.
    for (int t = 0; t < 20; t++) begin
      logic        lng;
      logic [39:0] r;
      int          d;
      lng = 1'($urandom_range(0, 1));
      r   = lng ? {1'b0, 7'($urandom), $urandom} : {32'd0, 1'b0, 7'($urandom)};
      d   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(60, 66)) : int'($urandom_range(0, 12));
      run_txn(6'($urandom), $urandom, 7'($urandom), lng, r, d, ($urandom_range(0, 3) == 0));
    end

    repeat (5) @(negedge clk);
    check_val("resp_pulses", 64'(rv_count), 64'(n_txn));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
